// File: rtl/poscnt_pkg.sv
// poscnt_pkg: shared widths, sequencer states, write selects and velocity type for poscounter_array
package poscnt_pkg;
  localparam int VEL_MAG_MAX = 32;
  localparam logic WR_VEL = 1'b0;
  localparam logic WR_POS = 1'b1;
  typedef enum logic {IDLE, SWEEP} state_e;
  typedef struct packed {
    logic neg;
    logic [VEL_MAG_MAX-1:0] mag;
  } vel_t;
  function automatic int int_w(input int dac_w);
    return dac_w + 2;
  endfunction
  function automatic int acc_w(input int dac_w, input int frac_w);
    return int_w(dac_w) + frac_w;
  endfunction
endpackage

// File: rtl/poscnt_dacmap.sv
// poscnt_dacmap: registers one channel's clamped DAC code and in-range flag from its integer position
module poscnt_dacmap #(
  parameter int DAC_W = 10,
  parameter int INT_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [INT_W-1:0] p,
  output logic [DAC_W-1:0] dacout,
  output logic             vld
);
  logic neg, over, vld_d, vld_q;
  logic [DAC_W-1:0] dac_d, dac_q;
  always_comb begin
    neg = p[INT_W-1];
    over = !neg && |p[INT_W-2:DAC_W];
    vld_d = !neg && !over;
    dac_d = neg ? '0 : over ? '1 : p[DAC_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      dac_q <= '0;
      vld_q <= 1'b0;
    end else begin
      dac_q <= dac_d;
      vld_q <= vld_d;
    end
  end
  assign dacout = dac_q;
  assign vld = vld_q;
endmodule

// File: rtl/poscounter_array.sv
// poscounter_array: swept multi-channel position accumulator with shared adder; POSCNT_LIMIT_EN selects saturation and lim flags
module poscounter_array
  import poscnt_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DAC_W = 10,
  parameter int FRAC_W = 10,
  parameter int VEL_W = 10,
  localparam int INT_W = int_w(DAC_W),
  localparam int ACC_W = acc_w(DAC_W, FRAC_W),
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tick,
  input  logic [CHANNELS-1:0]       run,
  input  logic                      wr_en,
  input  logic                      wr_sel,
  input  logic [CW-1:0]             wr_chan,
  input  logic [INT_W-1:0]          wr_data,
  input  logic                      ovr_clr,
  output logic                      busy,
  output logic                      sweep_done,
  output logic                      overrun,
  output logic [CHANNELS*DAC_W-1:0] dacout,
  output logic [CHANNELS-1:0]       vld
`ifdef POSCNT_LIMIT_EN
  ,output logic [CHANNELS-1:0]      lim
`endif
);
  state_e state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic sweep_done_q, sweep_done_d, overrun_q, overrun_d, last;
  logic [ACC_W-1:0] acc_q [CHANNELS];
  logic [ACC_W-1:0] acc_d [CHANNELS];
  logic [VEL_W:0] vel_q [CHANNELS];
  logic [VEL_W:0] vel_d [CHANNELS];
  logic [CHANNELS-1:0] adv, pos_wr;
  vel_t vel;
  logic [ACC_W-1:0] cur, ext, nxt;
`ifdef POSCNT_LIMIT_EN
  logic [ACC_W:0] sum;
  logic sat;
  logic [CHANNELS-1:0] lim_q, lim_d;
`endif
  always_comb begin
    last = idx_q == CW'(CHANNELS - 1);
    state_d = state_q == IDLE ? (tick ? SWEEP : IDLE) : (last ? IDLE : SWEEP);
    idx_d = state_q == SWEEP && !last ? idx_q + 1'b1 : '0;
    sweep_done_d = state_q == SWEEP && last;
    overrun_d = (tick && state_q == SWEEP) || (overrun_q && !ovr_clr);
  end
  always_comb begin
    cur = acc_q[idx_q];
    vel = '{neg: vel_q[idx_q][VEL_W], mag: VEL_MAG_MAX'(vel_q[idx_q][VEL_W-1:0])};
    ext = ACC_W'(vel.mag);
`ifdef POSCNT_LIMIT_EN
    sum = vel.neg ? {cur[ACC_W-1], cur} - {1'b0, ext} : {cur[ACC_W-1], cur} + {1'b0, ext};
    sat = sum[ACC_W] != sum[ACC_W-1];
    nxt = sat ? {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}} : sum[ACC_W-1:0];
`else
    nxt = vel.neg ? cur - ext : cur + ext;
`endif
  end
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      adv[i] = state_q == SWEEP && idx_q == CW'(i) && run[i];
      pos_wr[i] = wr_en && wr_sel == WR_POS && wr_chan == CW'(i);
      acc_d[i] = pos_wr[i] ? {wr_data, FRAC_W'(0)} : adv[i] ? nxt : acc_q[i];
      vel_d[i] = wr_en && wr_sel == WR_VEL && wr_chan == CW'(i) ? wr_data[VEL_W:0] : vel_q[i];
`ifdef POSCNT_LIMIT_EN
      lim_d[i] = pos_wr[i] ? 1'b0 : lim_q[i] | (adv[i] & sat);
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      sweep_done_q <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i] <= '0;
        vel_q[i] <= '0;
      end
`ifdef POSCNT_LIMIT_EN
      lim_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      sweep_done_q <= sweep_done_d;
      overrun_q <= overrun_d;
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i] <= acc_d[i];
        vel_q[i] <= vel_d[i];
      end
`ifdef POSCNT_LIMIT_EN
      lim_q <= lim_d;
`endif
    end
  end
  for (genvar g = 0; g < CHANNELS; g++) begin : g_map
    poscnt_dacmap #(.DAC_W(DAC_W), .INT_W(INT_W)) u_map (
      .clk(clk),
      .reset(reset),
      .p(acc_q[g][ACC_W-1:FRAC_W]),
      .dacout(dacout[g*DAC_W +: DAC_W]),
      .vld(vld[g])
    );
  end
  assign busy = state_q == SWEEP;
  assign sweep_done = sweep_done_q;
  assign overrun = overrun_q;
`ifdef POSCNT_LIMIT_EN
  assign lim = lim_q;
`endif
endmodule

// File: tb/tb_poscounter_array.sv
// tb_poscounter_array: directed stimulus with a sweep_done-driven scoreboard for poscounter_array
`timescale 1ns/1ps
module tb_poscounter_array;
  logic clk = 1'b0, reset = 1'b1, tick = 1'b0, wr_en = 1'b0, wr_sel = 1'b0, ovr_clr = 1'b0;
  logic [3:0] run = '0;
  logic [1:0] wr_chan = '0;
  logic [11:0] wr_data = '0;
  logic busy, sweep_done, overrun;
  logic [39:0] dacout;
  logic [3:0] vld;
`ifdef POSCNT_LIMIT_EN
  logic [3:0] lim;
`endif
  typedef struct {
    string name;
    logic [39:0] dac;
    logic [3:0] vld;
    logic [3:0] lim;
  } exp_t;
  exp_t exp_q[$];
  int vectors = 0, miscompares = 0, n_done = 0;
  always #5 clk = ~clk;
  poscounter_array dut (
    .clk(clk), .reset(reset), .tick(tick), .run(run), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_chan(wr_chan), .wr_data(wr_data), .ovr_clr(ovr_clr), .busy(busy),
    .sweep_done(sweep_done), .overrun(overrun), .dacout(dacout), .vld(vld)
`ifdef POSCNT_LIMIT_EN
    , .lim(lim)
`endif
  );
  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask
  function automatic logic [39:0] pk(input int d0, input int d1, input int d2, input int d3);
    return {d3[9:0], d2[9:0], d1[9:0], d0[9:0]};
  endfunction
  task automatic wr(input logic sel, input int ch, input int data);
    @(negedge clk);
    wr_en = 1'b1;
    wr_sel = sel;
    wr_chan = 2'(ch);
    wr_data = 12'(data);
    @(negedge clk);
    wr_en = 1'b0;
  endtask
  task automatic wait_done(input int d0);
    int t = 0;
    while (n_done == d0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("sweep_timeout", 40'(n_done != d0), 40'(1));
    repeat (2) @(negedge clk);
  endtask
  task automatic sweep(input string name, input logic [39:0] dac, input logic [3:0] v, input logic [3:0] l);
    int d0 = n_done;
    exp_q.push_back('{name, dac, v, l});
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    wait_done(d0);
  endtask
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (sweep_done === 1'b1) begin
        n_done++;
        @(negedge clk);
        if (exp_q.size() == 0) chk("unexpected_sweep", 40'(1), 40'(0));
        else begin
          e = exp_q.pop_front();
          chk({e.name, "_dac"}, dacout, e.dac);
          chk({e.name, "_vld"}, 40'(vld), 40'(e.vld));
`ifdef POSCNT_LIMIT_EN
          chk({e.name, "_lim"}, 40'(lim), 40'(e.lim));
`endif
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int d0;
    reset = 1'b1;
    tick = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_dac", dacout, 40'(0));
    chk("rst_vld", 40'(vld), 40'(0));
    chk("rst_busy", 40'(busy), 40'(0));
    chk("rst_overrun", 40'(overrun), 40'(0));
    chk("rst_done", 40'(sweep_done), 40'(0));
    reset = 1'b0;
    tick = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 40'(busy), 40'(0));
    chk("post_rst_vld", 40'(vld), 40'hF);
    wr(1'b1, 1, 100);
    wr(1'b0, 1, 'h200);
    run = 4'b0010;
    sweep("t2a", pk(0, 100, 0, 0), 4'hF, 4'h0);
    sweep("t2b", pk(0, 101, 0, 0), 4'hF, 4'h0);
    wr(1'b1, 0, 0);
    wr(1'b0, 0, 'h401);
    run = 4'b0001;
    sweep("t3", pk(0, 101, 0, 0), 4'b1110, 4'h0);
    wr(1'b1, 2, 1023);
    wr(1'b0, 2, 1023);
    run = 4'b0100;
    sweep("t4a", pk(0, 101, 1023, 0), 4'b1110, 4'h0);
    sweep("t4b", pk(0, 101, 1023, 0), 4'b1010, 4'h0);
    run = 4'b0000;
    d0 = n_done;
    exp_q.push_back('{"t5", pk(0, 101, 1023, 0), 4'b1010, 4'h0});
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk("t5_busy_e0", 40'(busy), 40'(1));
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk("t5_overrun", 40'(overrun), 40'(1));
    @(negedge clk);
    chk("t5_busy_e3", 40'(busy), 40'(1));
    chk("t5_done_early", 40'(sweep_done), 40'(0));
    @(negedge clk);
    chk("t5_busy_e4", 40'(busy), 40'(0));
    chk("t5_done_e4", 40'(sweep_done), 40'(1));
    repeat (4) @(negedge clk);
    chk("t5_done_count", 40'(n_done - d0), 40'(1));
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    chk("t5_ovr_clr", 40'(overrun), 40'(0));
    d0 = n_done;
    exp_q.push_back('{"t5b", pk(0, 101, 1023, 0), 4'b1010, 4'h0});
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    tick = 1'b1;
    ovr_clr = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    ovr_clr = 1'b0;
    chk("t5_set_wins", 40'(overrun), 40'(1));
    wait_done(d0);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    chk("t5_ovr_clr2", 40'(overrun), 40'(0));
    wr(1'b1, 3, 2047);
    wr(1'b0, 3, 1023);
    run = 4'b1000;
    sweep("t6a", pk(0, 101, 1023, 1023), 4'b0010, 4'h0);
`ifdef POSCNT_LIMIT_EN
    sweep("t6b", pk(0, 101, 1023, 1023), 4'b0010, 4'b1000);
    sweep("t6c", pk(0, 101, 1023, 1023), 4'b0010, 4'b1000);
`else
    sweep("t6b", pk(0, 101, 1023, 0), 4'b0010, 4'h0);
    sweep("t6c", pk(0, 101, 1023, 0), 4'b0010, 4'h0);
`endif
    d0 = n_done;
    exp_q.push_back('{"t6_poswin", pk(0, 101, 1023, 500), 4'b1010, 4'h0});
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (3) @(negedge clk);
    wr_en = 1'b1;
    wr_sel = 1'b1;
    wr_chan = 2'd3;
    wr_data = 12'd500;
    @(negedge clk);
    wr_en = 1'b0;
    wait_done(d0);
    d0 = n_done;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 40'(busy), 40'(0));
    chk("abort_dac", dacout, 40'(0));
    chk("abort_vld", 40'(vld), 40'(0));
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_no_done", 40'(n_done - d0), 40'(0));
    chk("abort_vld_after", 40'(vld), 40'hF);
    chk("queue_empty", 40'(exp_q.size()), 40'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
